bus_mux_reg: RTL

//  Parametrised, registered successor to the datapath bus multiplexer. It selects one of
//  NUM_SRC WIDTH-bit sources onto the shared bus from one-hot "<src>out" drive requests.
//  It also keeps the last driven value, detects and counts multiple-driver conflicts,
//  and optionally arbitrates conflicts round-robin. It sits between register/ALU outputs and the bus.

---
 rtl/bus_mux_pkg.sv | 34 +++
 rtl/bus_arbiter.sv | 70 +++++++
 rtl/bus_mux_reg.sv | 125 ++++++++++++
 3 files changed

// File: rtl/bus_mux_pkg.sv
// Shared constants for the registered bus multiplexer: source indices, bus width and
// the saturation limit of the conflict counter.
package bus_mux_pkg;

  // Source indices on the shared datapath bus.
  localparam int unsigned SRC_R0     = 0;
  localparam int unsigned SRC_R1     = 1;
  localparam int unsigned SRC_R2     = 2;
  localparam int unsigned SRC_R3     = 3;
  localparam int unsigned SRC_R4     = 4;
  localparam int unsigned SRC_R5     = 5;
  localparam int unsigned SRC_R6     = 6;
  localparam int unsigned SRC_R7     = 7;
  localparam int unsigned SRC_R8     = 8;
  localparam int unsigned SRC_R9     = 9;
  localparam int unsigned SRC_R10    = 10;
  localparam int unsigned SRC_R11    = 11;
  localparam int unsigned SRC_R12    = 12;
  localparam int unsigned SRC_R13    = 13;
  localparam int unsigned SRC_R14    = 14;
  localparam int unsigned SRC_R15    = 15;
  localparam int unsigned SRC_HI     = 16;
  localparam int unsigned SRC_LO     = 17;
  localparam int unsigned SRC_ZHIGH  = 18;
  localparam int unsigned SRC_ZLOW   = 19;
  localparam int unsigned SRC_PC     = 20;
  localparam int unsigned SRC_MDR    = 21;
  localparam int unsigned SRC_INPORT = 22;
  localparam int unsigned SRC_CSIGN  = 23;

  localparam int unsigned BUS_WIDTH = 32;
  localparam logic [7:0]  CNT_MAX   = 8'd255;

endpackage

// File: rtl/bus_arbiter.sv
// Request vector to grant index. Lowest requesting index wins by default.
// With BUS_MUX_ROUND_ROBIN_EN defined, a pointer register holds the last granted index and
// the search starts just above it, wrapping modulo NUM_SRC.
module bus_arbiter
  import bus_mux_pkg::*;
#(
  parameter int unsigned NUM_SRC = 24,
  parameter int unsigned SEL_W   = $clog2(NUM_SRC)
) (
  input  logic               i_clock,
  input  logic               i_clear,
  input  logic [NUM_SRC-1:0] i_req,
  output logic [SEL_W-1:0]   o_idx,
  output logic               o_valid,
  output logic               o_multi
);

  logic [SEL_W-1:0] w_idx_lo;

  // Request summary: any request, and more than one request.
  always_comb begin
    o_valid = |i_req;
    o_multi = ($countones(i_req) > 1);
  end

  // Lowest asserted index; downward scan so the last hit is the lowest.
  always_comb begin
    w_idx_lo = '0;
    for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
      if (i_req[i]) w_idx_lo = SEL_W'(i);
    end
  end

`ifdef BUS_MUX_ROUND_ROBIN_EN
  logic [SEL_W-1:0] r_ptr;
  logic [SEL_W-1:0] w_idx_hi;
  logic             w_hi_found;

  // Lowest asserted index above the pointer; falls back to the overall lowest (wrap).
  always_comb begin
    w_idx_hi   = '0;
    w_hi_found = 1'b0;
    for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
      if (i_req[i] && (SEL_W'(i) > r_ptr)) begin
        w_idx_hi   = SEL_W'(i);
        w_hi_found = 1'b1;
      end
    end
    o_idx = w_hi_found ? w_idx_hi : w_idx_lo;
  end

  // Pointer follows the grant; idle cycles leave it untouched.
  always_ff @(posedge i_clock) begin
    if (i_clear) begin
      r_ptr <= SEL_W'(NUM_SRC - 1);
    end else if (o_valid) begin
      r_ptr <= o_idx;
    end
  end
`else
  logic w_unused_clk;
  assign w_unused_clk = i_clock ^ i_clear;

  // Fixed priority needs no state.
  always_comb begin
    o_idx = w_idx_lo;
  end
`endif

endmodule

// File: rtl/bus_mux_reg.sv
// Registered datapath bus multiplexer with idle hold and multi-driver conflict tracking.
// Optional build macro: BUS_MUX_ROUND_ROBIN_EN (round-robin conflict arbitration in
// bus_arbiter); without it, the lowest requesting index wins.
module bus_mux_reg
  import bus_mux_pkg::*;
#(
  parameter int unsigned WIDTH        = BUS_WIDTH,
  parameter int unsigned NUM_SRC      = 24,
  parameter int unsigned SEL_W        = $clog2(NUM_SRC),
  parameter int unsigned PIPE         = 1,
  parameter int unsigned HOLD_ON_IDLE = 1
) (
  input  logic                     i_clock,
  input  logic                     i_clear,
  input  logic [NUM_SRC*WIDTH-1:0] i_src_data,
  input  logic [NUM_SRC-1:0]       i_src_out,
  input  logic                     i_err_clear,
  output logic [WIDTH-1:0]         o_bus_out,
  output logic                     o_bus_valid,
  output logic [SEL_W-1:0]         o_bus_sel,
  output logic                     o_conflict,
  output logic                     o_conflict_sticky,
  output logic [7:0]               o_conflict_count
);

  logic [SEL_W-1:0] w_gnt_idx;
  logic             w_gnt_valid;
  logic             w_multi;
  logic [WIDTH-1:0] w_gnt_data;

  // r_bus is the output register when PIPE=1 and the idle hold register when PIPE=0.
  logic [WIDTH-1:0] r_bus, w_bus_nxt;
  logic             r_valid;
  logic [SEL_W-1:0] r_sel, w_sel_nxt;
  logic             r_conflict;
  logic             r_sticky, w_sticky_nxt;
  logic [7:0]       r_count, w_count_nxt;

  bus_arbiter #(
    .NUM_SRC (NUM_SRC),
    .SEL_W   (SEL_W)
  ) u_arbiter (
    .i_clock (i_clock),
    .i_clear (i_clear),
    .i_req   (i_src_out),
    .o_idx   (w_gnt_idx),
    .o_valid (w_gnt_valid),
    .o_multi (w_multi)
  );

  // Data of the granted source; the index never exceeds NUM_SRC-1.
  always_comb begin
    w_gnt_data = '0;
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      if (w_gnt_idx == SEL_W'(i)) w_gnt_data = i_src_data[i*WIDTH +: WIDTH];
    end
  end

  // Next bus/select value: capture on grant, otherwise hold or zero the data.
  always_comb begin
    w_bus_nxt = r_bus;
    w_sel_nxt = r_sel;
    if (w_gnt_valid) begin
      w_bus_nxt = w_gnt_data;
      w_sel_nxt = w_gnt_idx;
    end else if (HOLD_ON_IDLE == 0) begin
      w_bus_nxt = '0;
    end
  end

  // Conflict bookkeeping: a new conflict takes precedence over err_clear.
  always_comb begin
    w_sticky_nxt = r_sticky;
    w_count_nxt  = r_count;
    if (w_multi) begin
      w_sticky_nxt = 1'b1;
      if (i_err_clear) begin
        w_count_nxt = 8'd1;
      end else if (r_count != CNT_MAX) begin
        w_count_nxt = r_count + 8'd1;
      end
    end else if (i_err_clear) begin
      w_sticky_nxt = 1'b0;
      w_count_nxt  = 8'd0;
    end
  end

  // State registers; clear discards any in-flight transfer.
  always_ff @(posedge i_clock) begin
    if (i_clear) begin
      r_bus      <= '0;
      r_valid    <= 1'b0;
      r_sel      <= '0;
      r_conflict <= 1'b0;
      r_sticky   <= 1'b0;
      r_count    <= 8'd0;
    end else begin
      r_bus      <= w_bus_nxt;
      r_valid    <= w_gnt_valid;
      r_sel      <= w_sel_nxt;
      r_conflict <= w_multi;
      r_sticky   <= w_sticky_nxt;
      r_count    <= w_count_nxt;
    end
  end

  // Output selection: registered path, or combinational path backed by the hold register.
  always_comb begin
    if (PIPE != 0) begin
      o_bus_out   = r_bus;
      o_bus_valid = r_valid;
      o_bus_sel   = r_sel;
    end else begin
      o_bus_valid = w_gnt_valid;
      o_bus_sel   = w_gnt_valid ? w_gnt_idx : r_sel;
      if (w_gnt_valid)            o_bus_out = w_gnt_data;
      else if (HOLD_ON_IDLE != 0) o_bus_out = r_bus;
      else                        o_bus_out = '0;
    end
    o_conflict        = r_conflict;
    o_conflict_sticky = r_sticky;
    o_conflict_count  = r_count;
  end

endmodule
